// File: rtl/fir_mac_seq.sv
// Sequential signed MAC over NUM_TAPS sample/coef pairs, one product per cycle; optional MAC_ROUND_EN rounding.
// Result valid NUM_TAPS cycles after accept; held in DONE until outReady, input blocked until back in IDLE.
module fir_mac_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_TAPS   = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(NUM_TAPS),
   parameter int OUT_WIDTH  = 32,
   parameter int OUT_SHIFT  = 0
) (
   input  logic                           clk,
   input  logic                           rstN,
   input  logic [DATA_WIDTH*NUM_TAPS-1:0] pDataIn,
   input  logic [DATA_WIDTH*NUM_TAPS-1:0] coefs,
   input  logic                           inValid,
   output logic                           inReady,
   output logic [OUT_WIDTH-1:0]           macResult,
   output logic                           satFlag,
   output logic                           outValid,
   input  logic                           outReady
);

   localparam int IDX_W = $clog2(NUM_TAPS);
   localparam int AW1   = ACC_WIDTH + 1;
   localparam int SW    = (AW1 > OUT_WIDTH) ? AW1 : OUT_WIDTH;
   localparam logic [SW-1:0] ONE_W = SW'(1);
   localparam logic signed [SW-1:0] MAX_POS = signed'((ONE_W << (OUT_WIDTH-1)) - ONE_W);
   localparam logic signed [SW-1:0] MIN_NEG = ~MAX_POS;

`ifdef MAC_ROUND_EN
   localparam bit ROUND = (OUT_SHIFT > 0);
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                        state;
   logic signed [DATA_WIDTH-1:0]  samp_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  coef_q [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0]   acc;
   logic [IDX_W-1:0]              idx;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]   acc_sum;
   logic signed [AW1-1:0]         shifted;
   logic signed [SW-1:0]          shifted_w;
   logic [OUT_WIDTH-1:0]          res_d;
   logic                          sat_d;

   assign prod    = samp_q[idx] * coef_q[idx];
   assign acc_sum = acc + ACC_WIDTH'(prod);

   // One extra bit of headroom so the rounding bias can never wrap the sum
   generate
      if (ROUND) begin : g_round
         localparam logic signed [AW1-1:0] RND_BIAS = AW1'(1) << (OUT_SHIFT-1);
         logic signed [AW1-1:0] biased;
         assign biased  = AW1'(acc_sum) + RND_BIAS;
         assign shifted = biased >>> OUT_SHIFT;
      end else begin : g_trunc
         assign shifted = AW1'(acc_sum) >>> OUT_SHIFT;
      end
   endgenerate

   assign shifted_w = SW'(shifted);

   always_comb begin
      sat_d = 1'b0;
      res_d = shifted_w[OUT_WIDTH-1:0];
      if (shifted_w > MAX_POS) begin
         sat_d = 1'b1;
         res_d = MAX_POS[OUT_WIDTH-1:0];
      end else if (shifted_w < MIN_NEG) begin
         sat_d = 1'b1;
         res_d = MIN_NEG[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         inReady   <= 1'b0;
         outValid  <= 1'b0;
         macResult <= '0;
         satFlag   <= 1'b0;
         acc       <= '0;
         idx       <= '0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            samp_q[i] <= '0;
            coef_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (inReady && inValid) begin
                  for (int i = 0; i < NUM_TAPS; i++) begin
                     samp_q[i] <= pDataIn[i*DATA_WIDTH +: DATA_WIDTH];
                     coef_q[i] <= coefs[i*DATA_WIDTH +: DATA_WIDTH];
                  end
                  acc     <= '0;
                  idx     <= '0;
                  inReady <= 1'b0;
                  state   <= MAC;
               end else begin
                  inReady <= 1'b1;
               end
            end
            MAC: begin
               acc <= acc_sum;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NUM_TAPS-1)) begin
                  macResult <= res_d;
                  satFlag   <= sat_d;
                  outValid  <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (outReady) begin
                  outValid <= 1'b0;
                  inReady  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomized and directed bench for fir_mac_seq against a plain-arithmetic dot-product model.
module tb_fir_mac_seq;

   localparam int DW = 16;
   localparam int NT = 8;
   localparam int VW = DW*NT;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [VW-1:0] p_data, coef_vec;
   logic          in_valid, out_ready;
   logic          in_ready_a, in_ready_b, in_ready_c;
   logic          out_valid_a, out_valid_b, out_valid_c;
   logic          sat_a, sat_b, sat_c;
   logic [31:0]   res_a;
   logic [15:0]   res_b, res_c;

   logic [VW-1:0] vec_s, vec_c;
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fir_mac_seq u_a (
      .clk(clk), .rstN(rst_n), .pDataIn(p_data), .coefs(coef_vec), .inValid(in_valid),
      .inReady(in_ready_a), .macResult(res_a), .satFlag(sat_a), .outValid(out_valid_a),
      .outReady(out_ready));

   fir_mac_seq #(.OUT_WIDTH(16)) u_b (
      .clk(clk), .rstN(rst_n), .pDataIn(p_data), .coefs(coef_vec), .inValid(in_valid),
      .inReady(in_ready_b), .macResult(res_b), .satFlag(sat_b), .outValid(out_valid_b),
      .outReady(out_ready));

   fir_mac_seq #(.OUT_WIDTH(16), .OUT_SHIFT(2)) u_c (
      .clk(clk), .rstN(rst_n), .pDataIn(p_data), .coefs(coef_vec), .inValid(in_valid),
      .inReady(in_ready_c), .macResult(res_c), .satFlag(sat_c), .outValid(out_valid_c),
      .outReady(out_ready));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint dot(input logic [VW-1:0] s, input logic [VW-1:0] c);
      longint sum = 0;
      for (int i = 0; i < NT; i++)
         sum += longint'($signed(s[i*DW +: DW])) * longint'($signed(c[i*DW +: DW]));
      return sum;
   endfunction

   function automatic void scale(input longint sum, input int ow, input int sh,
                                 output logic [63:0] res, output logic sat);
      longint v, mx, mn;
      v = sum;
`ifdef MAC_ROUND_EN
      if (sh > 0) v = v + (longint'(1) << (sh-1));
`endif
      v  = v >>> sh;
      mx = (longint'(1) << (ow-1)) - 1;
      mn = -mx - 1;
      sat = 1'b1;
      if (v > mx)      v = mx;
      else if (v < mn) v = mn;
      else             sat = 1'b0;
      res = 64'(v) & ((64'd1 << ow) - 64'd1);
   endfunction

   task automatic fill(input int s, input int c);
      for (int i = 0; i < NT; i++) begin
         vec_s[i*DW +: DW] = 16'(s);
         vec_c[i*DW +: DW] = 16'(c);
      end
   endtask

   task automatic rand_vec(input bit full);
      for (int i = 0; i < NT; i++) begin
         if (full) begin
            vec_s[i*DW +: DW] = 16'($urandom);
            vec_c[i*DW +: DW] = 16'($urandom);
         end else begin
            vec_s[i*DW +: DW] = 16'(int'($urandom_range(15, 0)) - 8);
            vec_c[i*DW +: DW] = 16'(int'($urandom_range(15, 0)) - 8);
         end
      end
   endtask

   // Runs one transaction of vec_s/vec_c; hold>0 stalls outReady and offers a fresh vector meanwhile
   task automatic do_txn(input string tag, input int hold);
      logic [63:0] ea, eb, ec;
      logic        sa, sb, sc;
      longint      sum;
      int          w, lat;
      sum = dot(vec_s, vec_c);
      scale(sum, 32, 0, ea, sa);
      scale(sum, 16, 0, eb, sb);
      scale(sum, 16, 2, ec, sc);
      @(negedge clk);
      p_data = vec_s; coef_vec = vec_c; in_valid = 1'b1; out_ready = (hold == 0);
      w = 0;
      while (!in_ready_a && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w == 50) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      p_data   = {$urandom, $urandom, $urandom, $urandom};
      coef_vec = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      while (!out_valid_a && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(NT));
      chk({tag, "_valid_bc"}, {62'd0, out_valid_b, out_valid_c}, 64'd3);
      chk({tag, "_inready_busy"}, 64'(in_ready_a), 64'd0);
      chk({tag, "_res_a"}, 64'(res_a), ea);
      chk({tag, "_sat_a"}, 64'(sat_a), 64'(sa));
      chk({tag, "_res_b"}, 64'(res_b), eb);
      chk({tag, "_sat_b"}, 64'(sat_b), 64'(sb));
      chk({tag, "_res_c"}, 64'(res_c), ec);
      chk({tag, "_sat_c"}, 64'(sat_c), 64'(sc));
      if (hold > 0) begin
         rand_vec($urandom_range(1, 0) == 1);
         p_data = vec_s; coef_vec = vec_c; in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(out_valid_a), 64'd1);
            chk({tag, "_hold_inready"}, 64'(in_ready_a), 64'd0);
            chk({tag, "_hold_res"}, 64'(res_a), ea);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 64'(out_valid_a), 64'd0);
      chk({tag, "_inready_back"}, 64'(in_ready_a), 64'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; p_data = '0; coef_vec = '0;
      vec_s = '0; vec_c = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {28'd0, out_valid_a, sat_a, in_ready_a, |res_a}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_inready", 64'(in_ready_a), 64'd1);

      for (int i = 0; i < NT; i++) begin
         vec_s[i*DW +: DW] = 16'd1;
         vec_c[i*DW +: DW] = 16'(i + 1);
      end
      do_txn("ramp", 0);
      fill(-1, 1);         do_txn("neg8", 0);
      fill(32767, 32767);  do_txn("satpos", 0);
      fill(-32768, 32767); do_txn("satneg", 0);
      fill(-32768, -32768); do_txn("minmin", 0);
      fill(1, 0);
      for (int i = 0; i < 6; i++) vec_c[i*DW +: DW] = 16'd1;
      do_txn("sum6", 0);
      fill(-1, 0);
      for (int i = 0; i < 6; i++) vec_c[i*DW +: DW] = 16'd1;
      do_txn("sum_m6", 5);
      do_txn("after_hold", 0);

      for (int t = 0; t < 20; t++) begin
         rand_vec(t[0]);
         do_txn("rand", (t % 5 == 2) ? int'($urandom_range(4, 1)) : 0);
      end

      rand_vec(1'b1);
      @(negedge clk);
      p_data = vec_s; coef_vec = vec_c; in_valid = 1'b1;
      cnt = 0;
      while (!in_ready_a && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outs", {28'd0, out_valid_a, sat_a, in_ready_a, |res_a}, 64'd0);
      chk("abort_outs_bc", {60'd0, |res_b, |res_c, sat_b, sat_c}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid_a) cnt++;
      end
      chk("abort_no_valid", 64'(cnt), 64'd0);
      rand_vec(1'b1);
      do_txn("post_abort", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
- Sequential, parametrised multiply-accumulate engine for the FIR datapath.
- Sits between the tap shift register (parallel sample vector) and the output stage.
- Accepts one sample/coefficient vector per transaction through a valid/ready handshake and computes one signed product per cycle into a wide accumulator.
- Returns a scaled, saturated result through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, width of each signed sample and each signed coefficient
- NUM_TAPS, 8, taps per transaction; must be ≥2
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(NUM_TAPS), signed accumulator width; guarantees no internal overflow
- OUT_WIDTH, 32, signed result width
- OUT_SHIFT, 0, arithmetic right shift applied to the final sum before saturation; range 0..ACC_WIDTH-1

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- pDataIn  in  DATA_WIDTH*NUM_TAPS  flattened signed samples; tap i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- coefs  in  DATA_WIDTH*NUM_TAPS  flattened signed coefficients; same packing as pDataIn
- inValid  in  1  pDataIn/coefs valid
- inReady  out  1  block can accept a vector
- macResult  out  OUT_WIDTH  signed scaled, saturated sum
- satFlag  out  1  macResult was clipped; qualified by outValid
- outValid  out  1  macResult valid
- outReady  in  1  consumer accepts macResult

Behaviour:
- Reset (rstN low, asynchronous):
  - state=IDLE, macResult=0, satFlag=0, outValid=0, accumulator=0, index=0.
  - inReady=1 after reset release.
  - Reset mid-transaction aborts it with no output.
- States:
  - IDLE: inReady=1, outValid=0. On inValid&&inReady: latch pDataIn and coefs into internal registers, clear accumulator, index=0, go to MAC.
  - MAC: inReady=0. Each cycle: acc += sext(sample[index])*sext(coef[index]) (signed, 2*DATA_WIDTH product sign-extended to ACC_WIDTH); index++.
    - On index==NUM_TAPS-1, compute final = acc + last product, then shift/round/saturate.
    - Load macResult and satFlag, set outValid=1, go to DONE.
  - DONE: outValid=1, inReady=0, macResult/satFlag held stable. On outReady high: outValid=0, go to IDLE.
- Latency:
  - Vector accepted on edge k → outValid high after edge k+NUM_TAPS.
  - Minimum transaction period is NUM_TAPS+2 cycles (IDLE, NUM_TAPS MAC cycles, DONE with outReady=1).
- Input changes while not in IDLE are ignored; latched copies are used.
- Scaling:
  - shifted = final >>> OUT_SHIFT (arithmetic, floor toward −inf).
  - If shifted > 2^(OUT_WIDTH-1)-1: macResult=max positive, satFlag=1.
  - If shifted < −2^(OUT_WIDTH-1): macResult=min negative, satFlag=1.
  - Otherwise macResult=shifted[OUT_WIDTH-1:0], satFlag=0.
  - When OUT_WIDTH ≥ ACC_WIDTH-OUT_SHIFT, no saturation is possible; result is sign-extended.
- Extremes: −2^(DATA_WIDTH-1) × −2^(DATA_WIDTH-1) must accumulate exactly (covered by ACC_WIDTH).
- inValid asserted in DONE: no acceptance until IDLE; the upstream must hold the vector.

Optional Feature:
- Macro MAC_ROUND_EN.
- Defined and OUT_SHIFT>0: shifted = (final + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half toward +inf. Addition is performed at ACC_WIDTH+1 bits so it cannot wrap. Saturation is applied afterwards.
- Undefined, or OUT_SHIFT==0: plain truncating arithmetic shift. No extra adder is instantiated.

Test Plan:
- DATA_WIDTH=16, NUM_TAPS=8, OUT_SHIFT=0; samples all 1, coefs 1..8, outReady=1 → macResult=36, satFlag=0; outValid exactly 8 cycles after the accept edge, high 1 cycle; inReady back high the cycle after.
- Samples all −1, coefs all 1 → macResult=−8 (0xFFFFFFF8 at OUT_WIDTH=32), satFlag=0.
- OUT_WIDTH=16; samples all 32767, coefs all 32767 → macResult=32767, satFlag=1. Samples all −32768, coefs all 32767 → macResult=−32768, satFlag=1.
- OUT_SHIFT=2; sum 6 → 1 without MAC_ROUND_EN, 2 with it. Sum −6 → −2 without, −1 with.
- outReady held low 5 cycles after outValid; inValid held high with a new vector → macResult stable, inReady=0 throughout. After outReady: second vector accepted, and its result matches the second vector, not the first.
- rstN pulsed low asynchronously mid-MAC (index 3) → all outputs 0 immediately. No outValid for the aborted vector; the next vector after release computes correctly.
